// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues one word request at a time to a variable-latency
// instruction memory, squashes stale responses after a redirect and presents
// one instruction to decode through a valid/stall hold register.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   FETCH  | no access in flight; request when the output slot is free
//   WAIT   | request in flight for PC; response will be captured
//   SQUASH | request in flight is stale; drop its response, then FETCH
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [31:0] new_pc,
    input  logic        pc_write_disable,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_PC,
    output logic [31:0] out_instruction
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_pc;
    logic         consume;
    logic         slot_free;
    logic         capture;

    assign redirect_pc = new_pc & ~32'h0000_0003;
    assign consume     = out_valid && !pc_write_disable;
    assign slot_free   = !out_valid || consume;
    assign mem_addr    = {2'b00, pc_q[31:2]};

    // Next-state, next-PC and request strobe.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mem_req = 1'b0;
        capture = 1'b0;
        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    pc_d = redirect_pc;
                end else if (slot_free) begin
                    mem_req = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = FETCH;
                    if (branch_taken) begin
                        pc_d = redirect_pc;
                    end else begin
                        capture = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end
                end else if (branch_taken) begin
                    pc_d    = redirect_pc;
                    state_d = SQUASH;
                end
            end
            SQUASH: begin
                if (branch_taken) begin
                    pc_d = redirect_pc;
                end
                // The stale response ends the squash even if another redirect
                // lands on the same cycle; nothing else is in flight to wait for.
                if (mem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Output hold register: a redirect kills the presented instruction,
    // a capture loads a new one, a consume without capture empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_PC          <= RESET_PC;
            out_instruction <= NOP_INSTR;
        end else begin
            if (branch_taken) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
            if (capture) begin
                out_PC          <= pc_q;
                out_instruction <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: programmable-latency memory, a behavioural model
// tracking in-flight/stale flags, a reset vector table, directed corner
// sequences and a randomized phase.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken;
    logic [31:0] new_pc;
    logic        pc_write_disable;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_PC;
    logic [31:0] out_instruction;

    fetch_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .branch_taken     (branch_taken),
        .new_pc           (new_pc),
        .pc_write_disable (pc_write_disable),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .out_valid        (out_valid),
        .out_PC           (out_PC),
        .out_instruction  (out_instruction)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // imem_model: one outstanding access, latency chosen at issue time
    int          lat = 1;
    logic        pend = 1'b0;
    int          due = 0;
    logic [31:0] paddr = 32'h0;

    // reference model: architectural PC, output register, in-flight flags
    logic        m_init = 1'b0;
    logic [31:0] m_pc, m_op, m_oi;
    logic        m_ov, m_busy, m_stale;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait budget expired (cycle %0d)", name, cyc);
    endtask

    function automatic logic model_req();
        return !m_busy && (!m_ov || !pc_write_disable) && !branch_taken;
    endfunction

    task automatic mem_drive();
        mem_rvalid = pend && (cyc == due);
        mem_rdata  = mem_rvalid ? word(paddr) : $urandom;
    endtask

    // Drive this cycle's inputs, let outputs settle, compare against the model.
    task automatic apply(input logic rst, input logic bt, input logic [31:0] npc, input logic stall);
        reset            = rst;
        branch_taken     = bt;
        new_pc           = npc;
        pc_write_disable = stall;
        #1;
        if (m_init) begin
            chk("model_req", 32'(mem_req), 32'(model_req()));
            if (model_req()) chk("model_addr", mem_addr, m_pc >> 2);
            chk("model_valid", 32'(out_valid), 32'(m_ov));
            chk("model_pc", out_PC, m_op);
            chk("model_instr", out_instruction, m_oi);
        end
    endtask

    // Clock edge: update memory and model from this cycle's inputs.
    task automatic advance();
        logic ereq;
        logic captured;
        ereq     = model_req();
        captured = 1'b0;
        if (reset) begin
            pend    = 1'b0;
            m_init  = 1'b1;
            m_pc    = DEFAULT_RESET_PC;
            m_op    = DEFAULT_RESET_PC;
            m_oi    = NOP_INSTR;
            m_ov    = 1'b0;
            m_busy  = 1'b0;
            m_stale = 1'b0;
        end else begin
            if (mem_rvalid) pend = 1'b0;
            if (mem_req) begin
                pend  = 1'b1;
                due   = cyc + lat;
                paddr = mem_addr;
            end
            if (ereq) begin
                m_busy  = 1'b1;
                m_stale = 1'b0;
            end else if (m_busy && mem_rvalid) begin
                if (!m_stale && !branch_taken) begin
                    m_oi     = word(m_pc >> 2);
                    m_op     = m_pc;
                    m_ov     = 1'b1;
                    m_pc     = m_pc + 32'd4;
                    captured = 1'b1;
                end
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end
            if (branch_taken) begin
                m_pc = new_pc & ~32'h3;
                m_ov = 1'b0;
                if (m_busy) m_stale = 1'b1;
            end else if (m_ov && !pc_write_disable && !captured) begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_drive();
    endtask

    typedef struct {
        logic        rst;
        logic        chk;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] pcs[8];
    int          at[8];
    int          n;
    int          rel;
    logic        issued;

    initial begin
        reset = 1'b1; branch_taken = 1'b0; new_pc = '0; pc_write_disable = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;

        //           rst  chk  req  addr   ov   out_PC  out_instruction
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'h0, NOP_INSTR};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0, NOP_INSTR};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'd1, 1'b1, 32'h0, 32'h1000_0000};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0, 32'h1000_0000};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'd2, 1'b1, 32'h4, 32'h1000_0001};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h4, 32'h1000_0001};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 32'd3, 1'b1, 32'h8, 32'h1000_0002};

        @(posedge clk);
        #1;
        mem_drive();

        // reset release and first fetches at latency 1
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].rst, 1'b0, 32'h0, 1'b0);
            if (vecs[i].chk) begin
                chk("vec_req", 32'(mem_req), 32'(vecs[i].e_req));
                if (vecs[i].e_req) chk("vec_addr", mem_addr, vecs[i].e_addr);
                chk("vec_valid", 32'(out_valid), 32'(vecs[i].e_ov));
                chk("vec_pc", out_PC, vecs[i].e_pc);
                chk("vec_instr", out_instruction, vecs[i].e_ins);
            end
            advance();
        end

        // stall: instruction at 0xC held for 5 cycles, no request
        apply(0, 0, 0, 0);
        advance();
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 1);
            chk("stall_req", 32'(mem_req), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc", out_PC, 32'hC);
            chk("stall_instr", out_instruction, 32'h1000_0003);
            advance();
        end
        lat = 3;
        apply(0, 0, 0, 0);
        chk("release_req", 32'(mem_req), 32'd1);
        chk("release_addr", mem_addr, 32'd4);
        advance();

        // redirect while waiting: stale response dropped, refetch from 0x40
        apply(0, 1, 32'h40, 0);
        chk("bt_wait_req", 32'(mem_req), 32'd0);
        advance();
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0);
            chk("squash_valid", 32'(out_valid), 32'd0);
            chk("squash_req", 32'(mem_req), 32'd0);
            advance();
        end
        apply(0, 0, 0, 0);
        chk("refetch_req", 32'(mem_req), 32'd1);
        chk("refetch_addr", mem_addr, 32'h10);
        advance();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0);
            advance();
        end
        apply(0, 0, 0, 0);
        chk("redir_valid", 32'(out_valid), 32'd1);
        chk("redir_pc", out_PC, 32'h40);
        chk("redir_instr", out_instruction, 32'h1000_0010);
        advance();

        // redirect on the response cycle
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0);
            advance();
        end
        apply(0, 1, 32'h103, 0);
        chk("bt_rv_rvalid", 32'(mem_rvalid), 32'd1);
        advance();
        apply(0, 0, 0, 0);
        chk("bt_rv_valid", 32'(out_valid), 32'd0);
        chk("bt_rv_req", 32'(mem_req), 32'd1);
        chk("bt_rv_addr", mem_addr, 32'h40);
        advance();

        // throughput at latency 3 from reset
        apply(1, 0, 0, 0);
        advance();
        rel = cyc;
        n = 0;
        for (int k = 0; k < 40 && n < 8; k++) begin
            apply(0, 0, 0, 0);
            if (out_valid) begin
                pcs[n] = out_PC;
                at[n]  = cyc;
                n++;
            end
            advance();
        end
        if (n < 8) expired("thr_count");
        if (n > 0) chk("thr_first", 32'(at[0] - rel), 32'd4);
        for (int k = 0; k < n; k++) begin
            chk("thr_pc", pcs[k], 32'(k * 4));
            if (k > 0) chk("thr_gap", 32'(at[k] - at[k-1]), 32'd4);
        end

        // reset in the middle of an access
        issued = 1'b0;
        for (int k = 0; k < 20 && !issued; k++) begin
            apply(0, 0, 0, 0);
            issued = mem_req;
            advance();
        end
        if (!issued) expired("rst_wait_issue");
        apply(1, 0, 0, 0);
        advance();
        apply(1, 0, 0, 0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_PC, DEFAULT_RESET_PC);
        chk("rst_instr", out_instruction, NOP_INSTR);
        advance();
        apply(0, 0, 0, 0);
        chk("rst_req", 32'(mem_req), 32'd1);
        chk("rst_addr", mem_addr, DEFAULT_RESET_PC >> 2);
        advance();

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            lat = $urandom_range(1, 4);
            apply(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 9) == 0),
                  $urandom,
                  ($urandom_range(0, 2) == 0));
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer between the program counter and a variable-latency, single-outstanding instruction memory. It issues word-address requests, tracks the one in-flight access, and squashes stale responses after a redirect. It presents one instruction at a time to decode through a valid/stall hold register. It replaces free-running PC+4 fetch whenever instruction memory takes one or more cycles to respond.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- branch_taken  in  1  redirect from execute; honoured in every state, overrides stall.
- new_pc  in  32  redirect target; bits [1:0] forced to 0.
- pc_write_disable  in  1  decode stall; while out_valid=1, the output is not consumed.
- mem_req  out  1  one-cycle request strobe.
- mem_addr  out  32  word address {2'b00, PC[31:2]}.
- mem_rvalid  in  1  response strobe; at least 1 cycle after mem_req; at most one outstanding.
- mem_rdata  in  32  instruction word, valid with mem_rvalid.
- out_valid  out  1  out_PC/out_instruction hold a live instruction.
- out_PC  out  32  address of the presented instruction.
- out_instruction  out  32  presented instruction.

## Operation
- Registers: PC, state, out_valid, out_PC, out_instruction.
- Consume event: out_valid && !pc_write_disable.
- Slot free: !out_valid || consume event.
- States:
  - FETCH: mem_req = slot free && !branch_taken.
    - On issue, go to WAIT.
    - Slot not free: remain in FETCH, mem_req=0.
  - WAIT: waiting on mem_rvalid.
    - rvalid && !branch_taken: out_instruction<=mem_rdata, out_PC<=PC, out_valid<=1, PC<=PC+4, go to FETCH.
    - rvalid && branch_taken: drop response, PC<=new_pc, go to FETCH.
    - !rvalid && branch_taken: PC<=new_pc, go to SQUASH.
  - SQUASH: next mem_rvalid is discarded, then go to FETCH.
    - branch_taken here updates PC and stays in SQUASH.
- Redirect: branch_taken sets PC<=new_pc & ~3 and out_valid<=0 in every state. In FETCH it also suppresses that cycle's mem_req.
- Consume without capture: out_valid<=0.
- Capture and consume cannot collide, because issue requires slot free.
- mem_addr is driven from PC combinationally in all states. It is meaningful only when mem_req=1.
- PC+4 wraps modulo 2^32.

## Timing
- Reset (synchronous): next edge sets PC=RESET_PC, state=FETCH, out_valid=0, out_PC=RESET_PC, out_instruction=32'h0000_0013 (NOP).
  - mem_req can be 1 in the first cycle after reset deasserts.
- Reset overrides all other inputs.
- The memory shares reset, so no response from before reset reaches the block after it.
- Latency: request in cycle t, response with latency L arrives in cycle t+L, out_valid=1 from cycle t+L+1.
- Throughput: one instruction per L+1 cycles with no stall.
- Redirect to first request: branch_taken in FETCH/WAIT-with-rvalid gives mem_req for new_pc the next cycle. In WAIT without rvalid, mem_req for new_pc comes the cycle after the stale response.
- Stall: out_* hold stable while out_valid && pc_write_disable && !branch_taken.

## Structure
- Shared package fetch_pkg: state enum {FETCH, WAIT, SQUASH}, NOP constant 32'h0000_0013, default RESET_PC.
- Single flat module; no sub-module.
- The bench provides an imem_model with programmable latency L (words indexed by mem_addr).

## Test plan
- Reset, L=1, word i = 32'h1000_0000+i:
  - Cycle 0 after release: mem_req=1, mem_addr=0.
  - Cycle 2: out_valid=1, out_PC=0, out_instruction=32'h1000_0000.
  - Cycle 4: out_PC=4.
- Stall: pc_write_disable=1 for 5 cycles with out_valid=1 → out_PC/out_instruction unchanged, mem_req=0 throughout. Release → mem_req=1 the same cycle.
- branch_taken in WAIT with new_pc=32'h40, L=3:
  - Stale response dropped (out_valid stays 0).
  - Next mem_addr=32'h10.
  - First out_PC=32'h40, out_instruction=32'h1000_0010.
- branch_taken in the same cycle as mem_rvalid, new_pc=32'h103 → response dropped, out_valid=0, next cycle mem_addr=32'h40.
- L=3, no stall, 8 instructions → out_valid pulses every 4 cycles; out_PC sequence 0,4,…,28.
- reset asserted mid-WAIT → next cycle out_valid=0, out_PC=RESET_PC, out_instruction=NOP; following cycle mem_req=1, mem_addr=RESET_PC>>2.
